// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a big-endian word stream into 512-bit blocks and appends
// the 0x80 terminator, zero fill and the 64-bit message bit length.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  data_i,
    input  logic         vld_i,
    input  logic         last_i,
    input  logic [2:0]   nbytes_i,
    output logic         in_rdy_o,
    output logic [511:0] blk_o,
    output logic         padded_o,
    output logic         blk_last_o,
    input  logic         blk_ack_i
);

    typedef enum logic [1:0] {FILL, EMIT, PAD} state_e;

    state_e            state_q;
    logic [15:0][31:0] blk_q;        // word w lives at blk_q[15-w]
    logic [3:0]        idx_q;
    logic [LEN_W-1:0]  len_q;
    logic              term_done_q;
    logic              msg_end_q;
    logic              padded_q;
    logic              blk_last_q;
    logic              in_rdy_q;

    logic [2:0]        nb_d;
    logic [31:0]       last_word_d;
    logic [LEN_W-1:0]  len_add_d;
    logic [63:0]       len64_d;
    logic [4:0]        pad_idx_d;
    logic [15:0][31:0] pad_blk_d;
    logic              pad_last_d;

    // Final word: keep n leading bytes, then the terminator byte if there is room.
    always_comb begin
        nb_d        = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
        last_word_d = data_i;
        for (int unsigned b = 0; b < 4; b++) begin
            if (b >= 32'(nb_d))
                last_word_d[31-8*b -: 8] = (b == 32'(nb_d)) ? 8'h80 : 8'h00;
        end
        len_add_d = LEN_W'({nb_d, 3'b000});
    end

    always_comb begin
        len64_d             = '0;
        len64_d[LEN_W-1:0]  = len_q;
        pad_idx_d           = term_done_q ? {1'b0, idx_q} : {1'b0, idx_q} + 5'd1;
        pad_blk_d           = blk_q;
        if (!term_done_q)
            pad_blk_d[4'd15 - idx_q] = 32'h8000_0000;
        for (int unsigned w = 0; w < 16; w++) begin
            if (w >= 32'(pad_idx_d))
                pad_blk_d[4'(15 - w)] = '0;
        end
        // Length only fits when words 14..15 are still free after the terminator.
        pad_last_d = (pad_idx_d <= 5'd14);
        if (pad_last_d)
            {pad_blk_d[1], pad_blk_d[0]} = len64_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            blk_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            term_done_q <= 1'b0;
            msg_end_q   <= 1'b0;
            padded_q    <= 1'b0;
            blk_last_q  <= 1'b0;
            in_rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_rdy_q <= 1'b1;
                    if (vld_i && in_rdy_q) begin
                        blk_q[4'd15 - idx_q] <= last_i ? last_word_d : data_i;
                        len_q <= len_q + (last_i ? len_add_d : LEN_W'(32));
                        if (last_i) begin
                            msg_end_q   <= 1'b1;
                            term_done_q <= (nb_d != 3'd4);
                        end
                        if (idx_q == 4'd15) begin
                            idx_q      <= '0;
                            state_q    <= EMIT;
                            padded_q   <= 1'b1;
                            blk_last_q <= 1'b0;
                            in_rdy_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (last_i) begin
                                state_q  <= PAD;
                                in_rdy_q <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    blk_q       <= pad_blk_d;
                    blk_last_q  <= pad_last_d;
                    padded_q    <= 1'b1;
                    term_done_q <= 1'b1;
                    idx_q       <= '0;
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (blk_ack_i) begin
                        padded_q   <= 1'b0;
                        blk_last_q <= 1'b0;
                        if (blk_last_q) begin
                            len_q       <= '0;
                            idx_q       <= '0;
                            term_done_q <= 1'b0;
                            msg_end_q   <= 1'b0;
                            state_q     <= FILL;
                            in_rdy_q    <= 1'b1;
                        end else if (msg_end_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q  <= FILL;
                            in_rdy_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_rdy_o   = in_rdy_q;
    assign blk_o      = blk_q;
    assign padded_o   = padded_q;
    assign blk_last_o = blk_last_q;

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Message-side front end for the SHA-256 core.
- Accepts a big-endian byte stream as 32-bit words over a valid/ready handshake.
- Appends the FIPS 180-4 padding: the 0x80 terminator, zero fill and the 64-bit message bit length.
- Presents complete 512-bit blocks, one at a time, on a valid/ack interface. This is the producer for the core's mess/padded_i inputs.

Parameters:
- LEN_W, 64, width of the message bit-length counter. The counter always occupies block words 14..15, zero-extended to 64 bits.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-low reset.
- data_i  in  32  Message word. Byte 0 is bits [31:24].
- vld_i  in  1  data_i is valid.
- last_i  in  1  Current word is the final word of the message.
- nbytes_i  in  3  Valid bytes in the last word, 0..4, left-aligned. Ignored unless last_i. Values >4 are treated as 4.
- in_rdy_o  out  1  Padder accepts a word this cycle.
- blk_o  out  512  Padded block. Word 0 is bits [511:480].
- padded_o  out  1  blk_o is valid.
- blk_last_o  out  1  Block is the final block of the message.
- blk_ack_i  in  1  Consumer takes blk_o. Sampled only while padded_o=1.

Behaviour:
- Reset (rst=0, async) values:
  - blk_o=0, padded_o=0, blk_last_o=0, in_rdy_o=0 until first clk after release.
  - Word index idx=0, length counter=0, term_done=0, state FILL.
  - Reset mid-operation discards the partial message and any held block. padded_o drops immediately.
- States: FILL, EMIT, PAD.
- FILL:
  - in_rdy_o=1. A word transfers on vld_i && in_rdy_o and is written to word idx. idx++ and length += 32.
  - idx reaching 16 without last_i -> EMIT with blk_last_o=0, then back to FILL at idx=0.
  - Last word with n = min(nbytes_i, 4):
    - Bytes n..3 are cleared. If n<4, byte n is set to 0x80 and term_done=1.
    - length += 8*n. idx++. Next state is PAD if idx<16. Otherwise next state is EMIT (blk_last_o=0) with term_done held and return to PAD.
  - nbytes_i=0 with last_i stores 0x80000000 at idx. This covers the empty message.
- PAD (exactly 1 cycle):
  - If !term_done, write 0x80000000 at idx, idx++, term_done=1.
  - Words idx..15 are zeroed.
  - If final idx<=14: words 14..15 = length, blk_last_o=1.
  - Otherwise blk_last_o=0, and after the ack the padder returns to PAD with idx=0. That block becomes zero words plus length.
  - Always -> EMIT.
- EMIT:
  - padded_o=1 and in_rdy_o=0. blk_o and blk_last_o are held stable until ack.
  - On blk_ack_i, padded_o=0 next cycle.
  - If blk_last_o: length, idx and term_done are cleared, then -> FILL.
  - If the message is pending: -> PAD (last already seen) or FILL (more data).
- Latency:
  - Final FILL transfer to padded_o = 2 cycles (PAD then EMIT).
  - Non-final full block: padded_o on the cycle after the 16th word transfer.
  - Ack to in_rdy_o = 1 cycle. There is no back-to-back bubble-free guarantee.
- Length arithmetic: modulo 2^LEN_W, wraps silently. The upper 64-LEN_W bits are 0.
- Boundary cases:
  - blk_ack_i while padded_o=0 is ignored.
  - vld_i with last_i while in EMIT is not accepted (in_rdy_o=0). The source holds the word.
  - Data is never lost or duplicated under arbitrary vld_i/blk_ack_i stalls.

Test Plan:
- "abc" (single word 0x61626300, nbytes=3, last):
  - Response: one block, blk_last_o=1.
  - Word 0 = 0x61626380, words 1..14 = 0, word 15 = 0x00000018.
  - padded_o 2 cycles after the transfer.
- Empty message (nbytes=0, last): one block with word 0 = 0x80000000 and all other words 0.
- 55 bytes (13 full words + last with nbytes=3):
  - One block. Word 13 = data bytes followed by 0x80.
  - Word 14 = 0, word 15 = 0x000001B8, blk_last_o=1.
- 56 bytes (last word at idx 13, nbytes=4):
  - Two blocks. Block 1: word 14 = 0x80000000, word 15 = 0, blk_last_o=0.
  - Block 2: words 0..14 = 0, word 15 = 0x000001C0, blk_last_o=1.
- 64 bytes:
  - Block 1 is the raw data, blk_last_o=0.
  - Block 2: word 0 = 0x80000000, word 15 = 0x00000200, blk_last_o=1.
- Backpressure and reset:
  - Hold blk_ack_i=0 for 10 cycles: blk_o is constant, padded_o=1 and in_rdy_o=0 throughout.
  - Assert rst=0 mid-FILL (idx=7): padded_o=0 immediately.
  - A following "abc" still produces exactly the "abc" block.
